// File: rtl/mux4_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mux4_bus_arbiter
// Purpose  : Round-robin arbiter and sequencer for a shared 4:1 byte bus.
//            Latches the winning requester's byte into a registered output,
//            completes a valid/ready transfer to one consumer, then pulses a
//            one-cycle acknowledge to the winner. A watchdog aborts transfers
//            the consumer never accepts.
// Ports    : CLK, RESET (sync, active-high)
//            req[3:0], d0..d3[DATA_W-1:0]   requester side
//            out_ready                      consumer accept
//            select[1:0], grant[3:0]        bus ownership (registered)
//            out_data, out_valid            registered transfer to consumer
//            ack[3:0], aborted, err         completion / timeout status
// Revision : 1.0  initial release
// ============================================================================
module mux4_bus_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    input  logic              out_ready,
    output logic [1:0]        select,
    output logic [3:0]        grant,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [3:0]        ack,
    output logic              aborted,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam bit         TO_EN   = (TIMEOUT != 0);
    // Counter value on which the abort edge fires; the counter is cleared on
    // the grant edge, so out_valid is seen for exactly TIMEOUT cycles.
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t            state, state_nx;
    logic [1:0]        ptr, ptr_nx;
    logic [7:0]        cnt, cnt_nx;
    logic [1:0]        select_nx;
    logic [3:0]        grant_nx, ack_nx;
    logic [DATA_W-1:0] data_nx;
    logic              valid_nx, aborted_nx, err_nx;

    logic [1:0]        win, cand;
    logic [DATA_W-1:0] win_data;

    // Round-robin scan: walk offsets from high to low so the requester
    // closest to ptr (smallest offset) is the last to overwrite win.
    always_comb begin
        win  = ptr;
        cand = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                win = cand;
            end
        end
    end

    always_comb begin
        case (win)
            2'd0:    win_data = d0;
            2'd1:    win_data = d1;
            2'd2:    win_data = d2;
            default: win_data = d3;
        endcase
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        cnt_nx     = cnt;
        select_nx  = select;
        grant_nx   = grant;
        data_nx    = out_data;
        valid_nx   = out_valid;
        ack_nx     = ack;
        aborted_nx = aborted;
        err_nx     = err;
        case (state)
            ST_IDLE: begin
                if (req != 4'd0) begin
                    select_nx = win;
                    grant_nx  = 4'b0001 << win;
                    data_nx   = win_data;
                    valid_nx  = 1'b1;
                    cnt_nx    = 8'd0;
                    state_nx  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A same-cycle accept wins over the watchdog.
                if (out_ready) begin
                    valid_nx   = 1'b0;
                    ack_nx     = 4'b0001 << select;
                    aborted_nx = 1'b0;
                    ptr_nx     = select + 2'd1;
                    state_nx   = ST_ACK;
                end else if (TO_EN && (cnt == TO_LAST)) begin
                    valid_nx   = 1'b0;
                    ack_nx     = 4'b0001 << select;
                    aborted_nx = 1'b1;
                    err_nx     = 1'b1;
                    ptr_nx     = select + 2'd1;
                    state_nx   = ST_ACK;
                end else if (cnt != 8'hFF) begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            ST_ACK: begin
                ack_nx     = 4'd0;
                aborted_nx = 1'b0;
                grant_nx   = 4'd0;
                state_nx   = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            ptr       <= 2'd0;
            cnt       <= 8'd0;
            select    <= 2'd0;
            grant     <= 4'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
            ack       <= 4'd0;
            aborted   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            select    <= select_nx;
            grant     <= grant_nx;
            out_data  <= data_nx;
            out_valid <= valid_nx;
            ack       <= ack_nx;
            aborted   <= aborted_nx;
            err       <= err_nx;
        end
    end

endmodule
`default_nettype wire
